// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer arbiter: FSM state encodings.
package interval_timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/interval_timer_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NUM_REQ. Returns the one-hot pick and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx
);

  logic found_s;
  int   pos_s;

  // Scan from the pointer upward and take the first active request.
  always_comb begin
    pick    = '0;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s = int'(ptr) + k;
      if (pos_s >= NUM_REQ) begin
        pos_s = pos_s - NUM_REQ;
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s]) begin
        found_s     = 1'b1;
        pick[pos_s] = 1'b1;
        idx         = IDX_W'(pos_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/interval_timer_arbiter.sv
// One shared interval down-counter time-multiplexed between NUM_REQ
// requesters by a round-robin arbiter; done pulses to the owner on expiry.
module interval_timer_arbiter
  import interval_timer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_en,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cur_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_r, state_nxt_s;
  logic [IDX_W-1:0]     owner_r, owner_nxt_s;
  logic [IDX_W-1:0]     ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [NUM_REQ-1:0]   grant_r, grant_nxt_s;
  logic [NUM_REQ-1:0]   done_r, done_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic [NUM_REQ-1:0]   pick_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [IDX_W-1:0]     owner_inc_s;
  logic [NUM_REQ-1:0]   owner_oh_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s),
    .idx  (pick_idx_s)
  );

  // Pointer successor of the current owner and its one-hot decode.
  always_comb begin
    if (owner_r == IDX_W'(NUM_REQ - 1)) begin
      owner_inc_s = '0;
    end else begin
      owner_inc_s = owner_r + IDX_W'(1);
    end
    owner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
  end

  // Next-state and next-output logic; all outputs leave through registers.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    grant_nxt_s = grant_r;
    done_nxt_s  = '0;
    busy_nxt_s  = busy_r;
    case (state_r)
      S_IDLE: begin
        if (|req) begin
          state_nxt_s = S_RUN;
          owner_nxt_s = pick_idx_s;
          cnt_nxt_s   = req_len[pick_idx_s*CNT_W +: CNT_W];
          grant_nxt_s = pick_s;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (!req[owner_r]) begin
          // Owner withdrew: release silently and move the pointer past it.
          state_nxt_s = S_IDLE;
          ptr_nxt_s   = owner_inc_s;
          cnt_nxt_s   = '0;
          grant_nxt_s = '0;
          busy_nxt_s  = 1'b0;
        end else if (cnt_r == '0) begin
          state_nxt_s = S_DONE;
          grant_nxt_s = '0;
          done_nxt_s  = owner_oh_s;
          busy_nxt_s  = 1'b1;
        end else if (tick_en) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        ptr_nxt_s   = owner_inc_s;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
        grant_nxt_s = '0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
      grant_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      grant_r <= grant_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign grant     = grant_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign cur_count = cnt_r;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: inputs change and outputs are
// checked on the falling edge, one task per scenario.
module tb_interval_timer_arbiter;
  import interval_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_en = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_len = 32'h0;
  logic [3:0]  grant, done;
  logic        busy;
  logic [7:0]  cur_count;
  int          errors = 0;
  int          checks = 0;

  interval_timer_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .req(req),
    .req_len(req_len), .grant(grant), .done(done), .busy(busy),
    .cur_count(cur_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0000; tick_en = 1'b0; req_len = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b1111; req_len = 32'h02020202; tick_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({grant, done, busy, cur_count} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {grant, done, busy, cur_count});
    end
    checks++;
    if (dut.state_r !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.state_r, ST_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 0001", grant);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_single_run();
    do_reset();
    req = 4'b0100; req_len[2*8 +: 8] = 8'd5; tick_en = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100 || cur_count !== 8'(6 - c) || done !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_run_c%0d: got g=%b cnt=%0d d=%b b=%b expected g=0100 cnt=%0d d=0000 b=1",
                 c, grant, cur_count, done, busy, 6 - c);
      end
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0100 || busy !== 1'b1 || cur_count !== 8'd0) begin
      errors++;
      $display("FAIL single_done: got g=%b d=%b b=%b cnt=%0d expected g=0000 d=0100 b=1 cnt=0",
               grant, done, busy, cur_count);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (done !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got d=%b b=%b expected d=0000 b=0", done, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [4];
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1011; req_len = 32'h01010101; tick_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++;
        if (grant !== order[t]) begin
          errors++;
          $display("FAIL rr_grant_t%0d: got %b expected %b", t, grant, order[t]);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== order[t] || grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_done_t%0d: got d=%b g=%b expected d=%b g=0000", t, done, grant, order[t]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000 || done !== 4'b0000) begin
        errors++;
        $display("FAIL rr_idle_t%0d: got b=%b g=%b d=%b expected idle zeros", t, busy, grant, done);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_tick_gating();
    int exp_cnt [10];
    exp_cnt = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
    do_reset();
    req = 4'b0001; req_len[7:0] = 8'd3; tick_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (cur_count !== 8'(exp_cnt[c-1]) || grant !== 4'b0001) begin
        errors++;
        $display("FAIL gate_c%0d: got cnt=%0d g=%b expected cnt=%0d g=0001",
                 c, cur_count, grant, exp_cnt[c-1]);
      end
      tick_en = (c % 3 == 0);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0001) begin
      errors++;
      $display("FAIL gate_done: got %b expected 0001", done);
    end
    req = 4'b0000; tick_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0110; req_len[1*8 +: 8] = 8'd6; req_len[2*8 +: 8] = 8'd2; tick_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || cur_count !== 8'd4) begin
      errors++;
      $display("FAIL abort_pre: got g=%b cnt=%0d expected g=0010 cnt=4", grant, cur_count);
    end
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || cur_count !== 8'd0) begin
      errors++;
      $display("FAIL abort_drop: got g=%b d=%b b=%b cnt=%0d expected all 0", grant, done, busy, cur_count);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || cur_count !== 8'd2 || done !== 4'b0000) begin
      errors++;
      $display("FAIL abort_next: got g=%b cnt=%0d d=%b expected g=0100 cnt=2 d=0000", grant, cur_count, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("FAIL abort_next_done: got %b expected 0100", done);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_len_zero();
    do_reset();
    req = 4'b1000; tick_en = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000 || cur_count !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL len0_grant: got g=%b cnt=%0d b=%b expected g=1000 cnt=0 b=1", grant, cur_count, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b1000 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL len0_done: got d=%b g=%b expected d=1000 g=0000", done, grant);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_len_max();
    int bad;
    bad = 0;
    do_reset();
    req = 4'b0001; req_len[7:0] = 8'hFF; tick_en = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      if (grant !== 4'b0001 || cur_count !== 8'(256 - c)) begin
        if (bad == 0)
          $display("FAIL lenmax_c%0d: got g=%b cnt=%0d expected g=0001 cnt=%0d", c, grant, cur_count, 256 - c);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lenmax_count: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || cur_count !== 8'd0) begin
      errors++;
      $display("FAIL lenmax_done: got d=%b cnt=%0d expected d=0001 cnt=0", done, cur_count);
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    do_reset();
    req = 4'b0010; req_len[1*8 +: 8] = 8'd10; tick_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, done, busy, cur_count} !== 17'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h expected 0", {grant, done, busy, cur_count});
    end
    req = 4'b0000;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrst_done: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_round_robin();
    test_tick_gating();
    test_abort();
    test_len_zero();
    test_len_max();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
